// File: rtl/bootrom_fetch_bridge_if.sv
// Bundle of the fetch/load request-response handshake and the boot ROM port.
// The master side is the SoC (requester plus ROM macro); the slave side is the bridge.
interface bootrom_fetch_bridge_if #(
  parameter int XLEN   = 32,
  parameter int ROM_AW = 10
);
  logic              req_valid;
  logic              req_ready;
  logic [XLEN-1:0]   req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [XLEN-1:0]   rsp_data;
  logic              rsp_err;
  logic              rom_ce;
  logic [ROM_AW-1:0] rom_addr;
  logic [XLEN-1:0]   rom_dout;

  modport master (
    output req_valid, req_addr, rsp_ready, rom_dout,
    input  req_ready, rsp_valid, rsp_data, rsp_err, rom_ce, rom_addr
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, rom_dout,
    output req_ready, rsp_valid, rsp_data, rsp_err, rom_ce, rom_addr
  );
endinterface

// File: rtl/bootrom_fetch_bridge.sv
// Boot ROM fetch bridge: decodes the ROM window, launches 1-cycle-latency ROM
// reads, and returns in-order responses (data or access fault) through a
// 3-entry FIFO. At most 3 requests are outstanding, so the FIFO cannot overflow.
module bootrom_fetch_bridge #(
  parameter int              XLEN   = 32,
  parameter logic [XLEN-1:0] BASE   = 32'h8000_0000,
  parameter logic [XLEN-1:0] RANGE  = 32'h0000_1000,
  parameter int              ROM_AW = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  bootrom_fetch_bridge_if.slave bus
);

  localparam int DEPTH = 3;

  // Decode: one extra bit keeps addresses below BASE from wrapping into the window.
  logic [XLEN:0]     addr_ext;
  logic [XLEN:0]     offset;
  logic              hit;
  logic [ROM_AW-1:0] word_addr;

  logic              req_ready_int;
  logic              rsp_valid_int;
  logic              accept;
  logic              pop;
  logic              rom_ce_int;

  logic [1:0]        o_reg;
  logic [1:0]        cnt_reg;
  logic [1:0]        wr_ptr_reg;
  logic [1:0]        rd_ptr_reg;
  logic              inf_v_reg;
  logic              inf_err_reg;
  logic [ROM_AW-1:0] rom_addr_reg;

  logic              fifo_wr;
  logic [XLEN-1:0]   fifo_wdata;
  logic [XLEN-1:0]   head_data;
  logic              head_err;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Window decode and byte-to-word address conversion.
  always_comb begin
    addr_ext  = {1'b0, bus.req_addr};
    offset    = addr_ext - {1'b0, BASE};
    hit       = (addr_ext >= {1'b0, BASE}) &&
                (offset < {1'b0, RANGE}) &&
                (bus.req_addr[1:0] == 2'b00);
    word_addr = offset[ROM_AW+1:2];
  end

  // Handshake qualifiers; req_ready depends only on registered state and rst.
  always_comb begin
    req_ready_int = !rst && (o_reg != 2'd3);
    rsp_valid_int = !rst && (cnt_reg != 2'd0);
    accept        = bus.req_valid && req_ready_int;
    pop           = rsp_valid_int && bus.rsp_ready;
    rom_ce_int    = accept && hit;
    fifo_wr       = inf_v_reg;
    fifo_wdata    = inf_err_reg ? '0 : bus.rom_dout;
  end

  // Outstanding-request counter: accept adds, pop removes, both together cancel.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_reg <= 2'd0;
    end else begin
      case ({accept, pop})
        2'b10:   o_reg <= o_reg + 2'd1;
        2'b01:   o_reg <= o_reg - 2'd1;
        default: o_reg <= o_reg;
      endcase
    end
  end

  // In-flight stage: remembers whether the request launched last cycle was a fault.
  always_ff @(posedge clk) begin
    if (rst) begin
      inf_v_reg   <= 1'b0;
      inf_err_reg <= 1'b0;
    end else begin
      inf_v_reg   <= accept;
      inf_err_reg <= !hit;
    end
  end

  // ROM address holds its last launched value between hits.
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr_reg <= '0;
    end else if (rom_ce_int) begin
      rom_addr_reg <= word_addr;
    end
  end

  // FIFO pointers and occupancy; write and pop in one cycle are both honoured.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= 2'd0;
      rd_ptr_reg <= 2'd0;
      cnt_reg    <= 2'd0;
    end else begin
      if (fifo_wr) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)     rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({fifo_wr, pop})
        2'b10:   cnt_reg <= cnt_reg + 2'd1;
        2'b01:   cnt_reg <= cnt_reg - 2'd1;
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

  // FIFO storage, one register pair per entry.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    logic [XLEN-1:0] data_reg;
    logic            err_reg;

    // Capture the in-flight response when this entry is the write target.
    always_ff @(posedge clk) begin
      if (rst) begin
        data_reg <= '0;
        err_reg  <= 1'b0;
      end else if (fifo_wr && (wr_ptr_reg == 2'(gi))) begin
        data_reg <= fifo_wdata;
        err_reg  <= inf_err_reg;
      end
    end
  end

  // Head-of-FIFO select.
  always_comb begin
    head_data = '0;
    head_err  = 1'b0;
    case (rd_ptr_reg)
      2'd0: begin head_data = g_ent[0].data_reg; head_err = g_ent[0].err_reg; end
      2'd1: begin head_data = g_ent[1].data_reg; head_err = g_ent[1].err_reg; end
      2'd2: begin head_data = g_ent[2].data_reg; head_err = g_ent[2].err_reg; end
      default: begin head_data = '0; head_err = 1'b0; end
    endcase
  end

  assign bus.req_ready = req_ready_int;
  assign bus.rsp_valid = rsp_valid_int;
  assign bus.rsp_data  = rsp_valid_int ? head_data : '0;
  assign bus.rsp_err   = rsp_valid_int && head_err;
  assign bus.rom_ce    = rom_ce_int;
  assign bus.rom_addr  = rst ? '0 : (rom_ce_int ? word_addr : rom_addr_reg);

endmodule
